// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier among NREQ requesters.
// Requester IDs ride a shift pipe alongside the multiplier; results are steered back to per-requester slots.

module fpu_mul_rsp_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant,
  input  logic        cap,
  input  logic        lost,
  input  logic        rdy,
  input  logic [31:0] mul_res,
  input  logic        mul_ovf,
  output logic        busy,
  output logic        vld,
  output logic [31:0] res,
  output logic        ovf
);
  logic drain;
  assign drain = vld && rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      vld  <= 1'b0;
      res  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (cap) begin
        vld <= 1'b1;
        res <= mul_res;
        ovf <= mul_ovf;
      end else if (drain) begin
        vld <= 1'b0;
      end
      // busy spans grant .. drain so the slot is always free when the result lands
      if (grant)              busy <= 1'b1;
      else if (drain || lost) busy <= 1'b0;
    end
  end
endmodule

module fpu_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_vld,
  input  logic [NREQ-1:0]      rsp_rdy,
  output logic [NREQ*32-1:0]   rsp_res,
  output logic [NREQ-1:0]      rsp_ovf,
  output logic                 mul_vld,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_res,
  input  logic                 mul_res_vld,
  input  logic                 mul_ovf,
  output logic                 err_unexp
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [NREQ-1:0][31:0] a_arr, b_arr, res_arr;
  logic [NREQ-1:0]       busy, elig, grant, cap, lost;
  logic [IDW-1:0]        ptr, win;
  logic                  win_vld;
  tag_t [MUL_LAT:0]      vld_pipe;
  tag_t                  tail;

  assign a_arr   = req_a;
  assign b_arr   = req_b;
  assign rsp_res = res_arr;
  assign elig    = req_vld & ~busy;
  assign tail    = vld_pipe[MUL_LAT];
  assign req_rdy = grant;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (rst && !win_vld && elig[j]) begin
        win_vld = 1'b1;
        win     = IDW'(j);
      end
    end
    if (win_vld) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      mul_vld   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      vld_pipe  <= '0;
      err_unexp <= 1'b0;
    end else begin
      mul_vld <= win_vld;
      if (win_vld) begin
        ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
        mul_a <= a_arr[win];
        mul_b <= b_arr[win];
      end
      vld_pipe[0] <= {win_vld, win};
      for (int k = 1; k <= MUL_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      // result without owner, or owner without result
      err_unexp <= err_unexp | (mul_res_vld ^ tail.vld);
    end
  end

  always_comb begin
    cap  = '0;
    lost = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tail.vld && tail.id == IDW'(i)) begin
        cap[i]  = mul_res_vld;
        lost[i] = !mul_res_vld;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    fpu_mul_rsp_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .grant   (grant[g]),
      .cap     (cap[g]),
      .lost    (lost[g]),
      .rdy     (rsp_rdy[g]),
      .mul_res (mul_res),
      .mul_ovf (mul_ovf),
      .busy    (busy[g]),
      .vld     (rsp_vld[g]),
      .res     (res_arr[g]),
      .ovf     (rsp_ovf[g])
    );
  end
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: behavioural FP32 multiplier plus a scoreboard that
// predicts grants, responses and error flags from the arbitration rules.

module tb_fpu_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_ovf;
  logic [NREQ-1:0][31:0] a_in, b_in;
  logic [NREQ*32-1:0]    rsp_res;
  logic                  mul_vld, mul_res_vld, m_vld, m_ovf, err_unexp;
  logic [31:0]           mul_a, mul_b, m_res;
  logic                  force_vld, drop_on;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic rst_edge;

  assign mul_res_vld = m_vld | force_vld;

  fpu_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(a_in), .req_b(b_in),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(m_res), .mul_res_vld(mul_res_vld), .mul_ovf(m_ovf),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  // Reference single-precision multiply: {overflow, result}; denormals treated as zero, truncating.
  function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s; logic [7:0] ea, eb; logic [22:0] fa, fb, mant; logic [23:0] ma, mb; logic [47:0] p; int e;
    s = a[31] ^ b[31]; ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return {1'b0, 32'h7FC00000};
    if ((ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0)) return {1'b1, 32'h7FC00000};
    if (ea == 8'hFF || eb == 8'hFF) return {1'b0, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    ma = {1'b1, fa}; mb = {1'b1, fb};
    p = 48'(ma) * 48'(mb);
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin e = e + 1; mant = p[46:24]; end
    else mant = p[45:23];
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], mant};
  endfunction

  // Multiplier stand-in, latency 1, sharing clk/rst; drop_on swallows results.
  always @(posedge clk) begin
    if (!rst) begin
      m_vld <= 1'b0; m_res <= '0; m_ovf <= 1'b0;
    end else begin
      m_vld <= mul_vld && !drop_on;
      {m_ovf, m_res} <= fmul(mul_a, mul_b);
    end
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Scoreboard state
  typedef struct { logic [31:0] res; logic ovf; int due; } exp_t;
  typedef struct { int cyc; int id; } tag_t;
  exp_t            exp_q[NREQ][$];
  tag_t            tq[$];
  logic [NREQ-1:0] busy_m, seen;
  int              ptr_m;
  logic            err_m, gnt_prev;
  logic [31:0]     prev_a, prev_b;

  always @(negedge clk) begin
    int w, j;
    logic [NREQ-1:0] elig, exp_rdy;
    logic [32:0] r;
    exp_t e;
    tag_t t;
    if (!rst) begin
      chk("rst_req_rdy", req_rdy, 0);
      if (!rst_edge) begin
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_mul_vld", mul_vld, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_err", err_unexp, 0);
      end
      ptr_m = 0; busy_m = '0; seen = '0; err_m = 0; gnt_prev = 0;
      tq.delete();
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    end else begin
      chk("err_unexp", err_unexp, err_m);
      chk("mul_vld", mul_vld, gnt_prev);
      if (gnt_prev) begin
        chk("mul_a", mul_a, prev_a);
        chk("mul_b", mul_b, prev_b);
      end
      elig = req_vld & ~busy_m;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr_m + k) % NREQ;
        if (w < 0 && elig[j]) w = j;
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_rdy", req_rdy, exp_rdy);

      for (int i = 0; i < NREQ; i++) begin
        if (exp_q[i].size() == 0) begin
          chk("rsp_vld_idle", rsp_vld[i], 0);
        end else if (rsp_vld[i]) begin
          if (!seen[i]) chk("rsp_latency", cyc, exp_q[i][0].due);
          chk("rsp_res", rsp_res[32*i +: 32], exp_q[i][0].res);
          chk("rsp_ovf", rsp_ovf[i], exp_q[i][0].ovf);
          if (rsp_rdy[i]) begin
            void'(exp_q[i].pop_front());
            seen[i] = 1'b0; busy_m[i] = 1'b0;
          end else seen[i] = 1'b1;
        end else begin
          chk("rsp_held", seen[i], 0);
          chk("rsp_late", cyc < exp_q[i][0].due, 1);
        end
      end

      if (tq.size() > 0 && tq[0].cyc == cyc) begin
        t = tq.pop_front();
        if (!mul_res_vld) begin
          err_m = 1'b1; busy_m[t.id] = 1'b0; exp_q[t.id].delete();
        end
      end else if (mul_res_vld) err_m = 1'b1;

      gnt_prev = 1'b0;
      if (w >= 0) begin
        busy_m[w] = 1'b1;
        ptr_m     = (w + 1) % NREQ;
        r         = fmul(a_in[w], b_in[w]);
        e.res = r[31:0]; e.ovf = r[32]; e.due = cyc + 2 + MUL_LAT;
        exp_q[w].push_back(e);
        t.cyc = cyc + 1 + MUL_LAT; t.id = w;
        tq.push_back(t);
        gnt_prev = 1'b1; prev_a = a_in[w]; prev_b = b_in[w];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input int i);
    bit ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_rdy[i]) ok = 1;
    end
    chk("grant_timeout", ok, 1);
  endtask

  // Directed op on one requester with fixed expected latency and value.
  task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf);
    a_in[i] = a; b_in[i] = b; rsp_rdy[i] = 1'b1;
    req_vld = '0; req_vld[i] = 1'b1;
    wait_rdy(i);
    tick();
    req_vld = '0;
    @(negedge clk); chk("dir_mul_vld", mul_vld, 1);
    @(negedge clk); chk("dir_rsp_early", rsp_vld[i], 0);
    @(negedge clk);
    chk("dir_rsp_vld", rsp_vld[i], 1);
    chk("dir_rsp_res", rsp_res[32*i +: 32], res);
    chk("dir_rsp_ovf", rsp_ovf[i], ovf);
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pending;
    req_vld = '0; rsp_rdy = '1; a_in = '0; b_in = '0;
    force_vld = 1'b0; drop_on = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    single(2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);

    // all requesters continuously valid, immediate drain
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = 32'h3F800000 + (i == 0 ? 32'h0 : 32'h00800000 * 32'(i == 1 ? 2 : (i == 2 ? 3 : 4)) / 2);
      b_in[i] = 32'h40000000;
    end
    a_in[0] = 32'h3F800000; a_in[1] = 32'h40000000; a_in[2] = 32'h40400000; a_in[3] = 32'h40800000;
    req_vld = '1; rsp_rdy = '1;
    repeat (40) tick();
    req_vld = '0;
    repeat (6) tick();

    // slot backpressure on requester 0
    a_in[0] = 32'h40A00000; b_in[0] = 32'h3FC00000;
    rsp_rdy[0] = 1'b0; req_vld = 4'b0001;
    repeat (14) tick();
    rsp_rdy[0] = 1'b1;
    repeat (3) tick();
    req_vld = '0;
    repeat (6) tick();

    single(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
    single(3, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1);

    repeat (300) begin
      tick();
      req_vld = NREQ'($urandom);
      rsp_rdy = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a_in[i] = $urandom; b_in[i] = $urandom;
      end
    end
    req_vld = '0; rsp_rdy = '1;
    repeat (10) tick();

    // reset in the cycle after a grant
    a_in[0] = 32'h40000000; b_in[0] = 32'h40000000;
    req_vld = 4'b0001;
    wait_rdy(0);
    tick();
    rst = 1'b0; req_vld = '0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    @(negedge clk); chk("reset_drop_rsp", rsp_vld, 0);
    tick();
    single(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    @(negedge clk); chk("post_reset_err", err_unexp, 0);
    tick();

    // result swallowed: owner without result
    drop_on = 1'b1;
    a_in[1] = 32'h40000000; b_in[1] = 32'h40000000;
    req_vld = 4'b0010;
    wait_rdy(1);
    tick();
    req_vld = '0;
    repeat (4) tick();
    drop_on = 1'b0;
    @(negedge clk);
    chk("drop_err", err_unexp, 1);
    chk("drop_no_rsp", rsp_vld[1], 0);
    tick();
    single(1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0);

    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // result without owner
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("unexp_err", err_unexp, 1);
      chk("unexp_rsp", rsp_vld, 0);
    end
    tick();

    pending = 0;
    for (int i = 0; i < NREQ; i++) pending += exp_q[i].size();
    chk("pending_left", pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Round-robin arbiter sharing one single-precision multiplier (`multiplier_32bit`) among NREQ requesters. Each requester has a valid/ready request channel and a one-entry response slot with valid/ready. The block registers the winning operands into the multiplier and tracks requester IDs through the multiplier latency. It steers each result, with its overflow flag, back to the originating requester. It sits between the FPU issue logic and the multiplier datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 1, cycles from multiplier `i_vld` sample to `o_res_vld` (1 for the current multiplier)
- clk  in  1  single clock, rising edge
- rst  in  1  reset: synchronous, active-low
- req_vld  in  NREQ  request valid, one bit per requester
- req_rdy  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a, req_b  in  NREQ*32  operands, requester i at bits [32i+31:32i]
- rsp_vld  out  NREQ  response slot full
- rsp_rdy  in  NREQ  requester drains its slot
- rsp_res  out  NREQ*32  result per requester
- rsp_ovf  out  NREQ  overflow flag per requester
- mul_vld  out  1  to multiplier `i_vld`
- mul_a, mul_b  out  32  to multiplier `i_a` / `i_b`
- mul_res  in  32  from multiplier `o_res`
- mul_res_vld  in  1  from multiplier `o_res_vld`
- mul_ovf  in  1  from multiplier `overflow`
- err_unexp  out  1  sticky: result arrived with no tracked owner

## Operation
- Per-requester `busy[i]` is set from grant until the response slot is drained. It covers in-flight ops and an occupied slot. Each requester has at most one outstanding op.
- Eligibility: requester i is eligible when `req_vld[i] && !busy[i]`.
- Arbitration: combinational round-robin over eligible requesters, starting at pointer `ptr` (0..NREQ-1). Exactly one winner per cycle, or none.
- `req_rdy[winner]` = 1 in the same cycle; all other bits are 0.
- On grant, `ptr` becomes winner+1, wrapping NREQ-1 to 0. With no grant, `ptr` holds.
- Issue stage: on grant, register `mul_a`, `mul_b` from the winner and set `mul_vld` = 1 for one cycle. With no grant, `mul_vld` = 0 and the operands hold.
- ID tracking: a shift pipe of MUL_LAT+1 entries, each {valid, id[$clog2(NREQ)-1:0]}. The winner is pushed at grant and advances every cycle. It is aligned so the tail entry coincides with `mul_res_vld`.
- Capture: when `mul_res_vld` && tail valid, write `mul_res` into `rsp_res[id]` and `mul_ovf` into `rsp_ovf[id]`, and set `rsp_vld[id]`.
- Unexpected result: `mul_res_vld` && tail invalid sets `err_unexp`, and the result is discarded. `err_unexp` clears only on reset.
- Tail valid without `mul_res_vld` is an error too: it sets `err_unexp` and clears `busy[id]`, with no response.
- Drain: `rsp_vld[i] && rsp_rdy[i]` clears `rsp_vld[i]` and `busy[i]`. The requester becomes eligible in the following cycle, not the same cycle.
- Results are passed through untouched. NaN, Inf and zero encodings come from the multiplier.

## Timing
- Reset values (rst=0 at a rising edge): `req_rdy` = 0, `rsp_vld` = 0, `rsp_res` = 0, `rsp_ovf` = 0, `mul_vld` = 0, `mul_a` = `mul_b` = 0, `err_unexp` = 0, `ptr` = 0. All `busy` bits and all ID pipe entries are cleared.
- Latency, with handshake in cycle T:
  - `mul_vld` = 1 in T+1.
  - `mul_res_vld` in T+1+MUL_LAT.
  - `rsp_vld` = 1 from T+2+MUL_LAT, i.e. T+3 for MUL_LAT=1.
- Throughput: one issue per cycle across distinct requesters. A single requester issues at most once every MUL_LAT+3 cycles, assuming immediate drain.
- `rsp_vld[i]` holds, with data stable, until drained. There is no backpressure on the multiplier, because each slot is reserved at grant.
- Simultaneous events:
  - Drain of slot i and capture for slot j≠i in the same cycle are both honoured.
  - Capture for slot i while `rsp_vld[i]` = 1 cannot occur, since `busy` blocks it.
- Reset mid-operation: in-flight ops are dropped and no response is produced. The multiplier shares `clk`/`rst`, so no stale result returns. If one does arrive after reset, it sets `err_unexp`.
- `req_rdy` depends combinationally on `req_vld`. No other output is combinational from an input.

## Test plan
- Single op: NREQ=4. Requester 2 sends a=0x40000000 (2.0), b=0x40400000 (3.0) at T, `rsp_rdy[2]`=1 → `req_rdy[2]` at T, `mul_vld` at T+1, `rsp_vld[2]` at T+3 with `rsp_res[2]`=0x40C00000 and `rsp_ovf[2]`=0.
- Round-robin fairness: all four requesters hold `req_vld` continuously with immediate drain → grant order 0,1,2,3,0,… with no requester granted twice before every other eligible one. Each response carries its own product, e.g. requester i sends a=(i+1).0, b=2.0.
- Slot backpressure: requester 0 holds `rsp_rdy[0]`=0 for 10 cycles → `rsp_vld[0]` and `rsp_res[0]` are stable, and `req_rdy[0]` stays 0 while `req_vld[0]`=1. After the drain, `req_rdy[0]` may rise no earlier than the next cycle.
- Overflow and special values: a=0x7F000000, b=0x7F000000 → `rsp_res`=0x7F800000, `rsp_ovf`=1. a=0x7F800000 (Inf), b=0 → 0x7FC00000, `rsp_ovf`=1.
- Reset mid-flight: assert rst=0 in the cycle after a grant → all outputs take reset values, and no `rsp_vld` occurs for the dropped op. After release, a new op completes normally and `err_unexp`=0.
- Unexpected result: force `mul_res_vld`=1 with no outstanding op → `err_unexp`=1 from the next cycle and stays 1 until reset. All `rsp_vld` bits are unchanged.
